// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder_mux.sv
// One-bit full adder built from 2:1 mux selections on the propagate term.
module full_adder_mux (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ? ~cin : cin;
    assign cout = p ? cin : a;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one bit pair per cycle, LSB first, carry held in a flop.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign cout     = carry_q;

    full_adder_mux u_slice (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ADD;
            ADD:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state_nx == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                    end
                end
                ADD: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum     <= {fa_s, sum[WIDTH-1:1]};
                    carry_q <= fa_c;
                    if (!last_bit) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl against an a+b+cin model.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    int           pulses;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Caller is positioned at the negedge opening an IDLE cycle; returns at the DONE cycle.
    task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic oc, input int inject_at);
        logic [W:0] r;
        int         n;
        chk({tag, " idle sum hold"}, 32'(sum), 32'(exp_sum));
        chk({tag, " idle cout hold"}, 32'(cout), 32'(exp_cout));
        chk({tag, " idle busy"}, 32'(busy), 32'(0));
        a = oa; b = ob; cin = oc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~oa; b = ~ob; cin = ~oc;
        chk({tag, " busy in add"}, 32'(busy), 32'(1));
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            if (n == inject_at) begin
                start = 1'b1; a = W'(8'h11); b = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        r = ref_add(oa, ob, oc);
        exp_sum  = r[W-1:0];
        exp_cout = r[W];
        chk({tag, " latency"}, 32'(n), 32'(W));
        chk({tag, " sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, " cout"}, 32'(cout), 32'(exp_cout));
        chk({tag, " busy in done"}, 32'(busy), 32'(1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset sum", 32'(sum), 32'(0));
        chk("reset cout", 32'(cout), 32'(0));

        // First edge with rst low takes the start
        rst = 1'b0;
        do_op("zero", 8'h00, 8'h00, 1'b0, -1);
        @(negedge clk);
        do_op("ff+01", 8'hFF, 8'h01, 1'b0, -1);
        @(negedge clk);
        do_op("a5+5a+1", 8'hA5, 8'h5A, 1'b1, -1);
        @(negedge clk);
        do_op("7f+01 ignore start", 8'h7F, 8'h01, 1'b0, 3);
        repeat (4) begin
            @(negedge clk);
            chk("no second done", 32'(done), 32'(0));
            chk("no queued op", 32'(busy), 32'(0));
        end

        do_op("b2b 03+04", 8'h03, 8'h04, 1'b0, -1);
        @(negedge clk);
        do_op("b2b f0+20", 8'hF0, 8'h20, 1'b0, -1);

        // Abort on the 4th ADD cycle
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'(0));
        chk("abort done", 32'(done), 32'(0));
        chk("abort sum", 32'(sum), 32'(0));
        chk("abort cout", 32'(cout), 32'(0));
        exp_sum = '0; exp_cout = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("abort no done", 32'(pulses), 32'(0));

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            do_op("random", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
